branch_redirect_ctrl: RTL and testbench

// - Sequences branch resolution for the 5-stage core: consumes the EX-stage taken

---
 rtl/branch_pkg.sv | 33 +++
 rtl/bht_2bit.sv | 34 +++
 rtl/branch_redirect_ctrl.sv | 133 +++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for branch resolution and the bimodal history table.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package branch_pkg;

    // Redirect sequencer states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // 2-bit saturating counter encodings
    localparam logic [1:0] SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] WT  = 2'b10;  // weakly taken
    localparam logic [1:0] ST  = 2'b11;  // strongly taken

    localparam logic [1:0]  BHT_INIT = WNT;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Saturating counter step: taken moves toward ST, not-taken toward SNT
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Bimodal history table of 2-bit saturating counters; MSB is the taken prediction.
// Latency: read is combinational; update lands on the next rising edge (read shows pre-update value).
// Backpressure: none; caller gates upd_en_i.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    logic [1:0] ctr_q [BHT_ENTRIES];

    // Counter array: reset to weakly not-taken, saturating train on update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr_q[i] <= BHT_INIT;
            end
        end else if (upd_en_i) begin
            ctr_q[upd_idx_i] <= ctr_update(ctr_q[upd_idx_i], upd_taken_i);
        end
    end

    assign rd_taken_o = ctr_q[rd_idx_i][1];

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves EX-stage branches/jal against their prediction, trains the BHT, issues PC redirect and flush.
// Latency: mispredict in EX at cycle N -> redirect pulse and flushes visible at cycle N+1.
// Backpressure: stall_in freezes resolution and holds the flush countdown; wrong-path EX ignored while flushing.
module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES  = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_in,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int IDX_W  = $clog2(BHT_ENTRIES);
    // Countdown needs at least one bit even when a single flush cycle is configured
    localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);

    state_e            state_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic              redirect_valid_q;
    logic [31:0]       redirect_pc_q;
    logic              flush_q;
    logic [CNT_W-1:0]  mispredict_cnt_q;

    logic              resolve;
    logic              actual;
    logic              mispredict;
    logic              train_en;
    logic [31:0]       correct_pc;

    logic [IDX_W-1:0]  if_idx;
    logic [IDX_W-1:0]  ex_idx;
    logic              unused_if_pc_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    // Only the word-aligned index bits of the fetch PC address the table
    assign unused_if_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Resolution decode: only real, unstalled control transfers while not squashing wrong-path work
    always_comb begin
        resolve    = 1'b0;
        actual     = 1'b0;
        mispredict = 1'b0;
        train_en   = 1'b0;
        correct_pc = 32'd0;
        resolve    = ex_valid & ~stall_in & (ex_is_branch | ex_is_jal) & (state_q == ST_IDLE);
        // jal wins when both flags are set: always taken and never trains
        actual     = ex_is_jal | ex_taken;
        mispredict = resolve & (actual != ex_pred_taken);
        train_en   = resolve & ex_is_branch & ~ex_is_jal;
        correct_pc = actual ? ex_target : (ex_pc + PC_STEP);
    end

    bht_2bit #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx_i    (if_idx),
        .rd_taken_o  (if_pred_taken),
        .upd_en_i    (train_en),
        .upd_idx_i   (ex_idx),
        .upd_taken_i (ex_taken)
    );

    // Redirect sequencer: one-cycle redirect pulse, flush held for FLUSH_CYCLES advancing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            fcnt_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            flush_q          <= 1'b0;
            mispredict_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mispredict) begin
                        state_q          <= ST_FLUSH;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= correct_pc;
                        flush_q          <= 1'b1;
                        fcnt_q           <= FCNT_INIT;
                        mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
                    end else begin
                        redirect_valid_q <= 1'b0;
                        flush_q          <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    redirect_valid_q <= 1'b0;
                    if (!stall_in) begin
                        if (fcnt_q == '0) begin
                            state_q <= ST_IDLE;
                            flush_q <= 1'b0;
                        end else begin
                            fcnt_q <= fcnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_ifid     = flush_q;
    assign flush_idex     = flush_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed vector table, reset-mid-flush sequence, random vs reference model.
// Latency: checks prediction before each edge and registered outputs 1ns after it.
// Backpressure: exercises stall_in in both idle and flush.
module tb_branch_redirect_ctrl;

    localparam int BHT_ENTRIES  = 64;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 16;

    logic             clk;
    logic             rst_n;
    logic             stall_in;
    logic [31:0]      if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic             ex_is_branch;
    logic             ex_is_jal;
    logic             ex_taken;
    logic             ex_pred_taken;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_target;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush_ifid;
    logic             flush_idex;
    logic [CNT_W-1:0] mispredict_cnt;

    int n_tests;
    int n_fail;

    branch_redirect_ctrl #(
        .BHT_ENTRIES  (BHT_ENTRIES),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_in       (stall_in),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_taken       (ex_taken),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        valid;
        logic        br;
        logic        jal;
        logic        taken;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [31:0] ifpc;
        logic        e_pred;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_fl;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: counters per entry, remaining advancing flush cycles, expected outputs
    int          m_bht[BHT_ENTRIES];
    int          m_left;
    logic        m_rv;
    logic [31:0] m_rpc;
    logic        m_fl;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic s, input logic v, input logic br, input logic jal,
                          input logic tk, input logic pr, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic [31:0] ipc);
        stall_in      = s;
        ex_valid      = v;
        ex_is_branch  = br;
        ex_is_jal     = jal;
        ex_taken      = tk;
        ex_pred_taken = pr;
        ex_pc         = pc;
        ex_target     = tgt;
        if_pc         = ipc;
    endtask

    // Called at posedge+1: checks prediction mid-cycle, then registered outputs after the edge
    task automatic cycle_check(input string tag, input logic e_pred, input logic e_rv,
                               input logic [31:0] e_rpc, input logic e_fl, input logic [15:0] e_cnt);
        #3;
        chk({tag, " pred"}, {31'd0, if_pred_taken}, {31'd0, e_pred});
        @(posedge clk);
        #1;
        chk({tag, " redirect_valid"}, {31'd0, redirect_valid}, {31'd0, e_rv});
        chk({tag, " redirect_pc"}, redirect_pc, e_rpc);
        chk({tag, " flush_ifid"}, {31'd0, flush_ifid}, {31'd0, e_fl});
        chk({tag, " flush_idex"}, {31'd0, flush_idex}, {31'd0, e_fl});
        chk({tag, " cnt"}, {16'd0, mispredict_cnt}, {16'd0, e_cnt});
    endtask

    task automatic model_reset();
        for (int i = 0; i < BHT_ENTRIES; i++) m_bht[i] = 1;
        m_left = 0;
        m_rv   = 1'b0;
        m_rpc  = 32'd0;
        m_fl   = 1'b0;
        m_cnt  = 0;
    endtask

    initial begin
        logic        s, v, br, jal, tk, pr, act, e_pred;
        logic [31:0] pc, tgt, ipc;
        int          idx;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);

        // Reset state
        #2;
        chk("rst redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst redirect_pc", redirect_pc, 32'd0);
        chk("rst flush_ifid", {31'd0, flush_ifid}, 32'd0);
        chk("rst flush_idex", {31'd0, flush_idex}, 32'd0);
        chk("rst cnt", {16'd0, mispredict_cnt}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            if_pc = $urandom;
            #1;
            chk($sformatf("rst pred pc=%h", if_pc), {31'd0, if_pred_taken}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        if_pc = 32'd0;

        // Directed vectors: stall,valid,br,jal,taken,pred,pc,tgt,ifpc, e_pred,e_rv,e_rpc,e_fl,e_cnt
        tbl.push_back('{0,1,1,0,1,0, 32'h100,32'h080, 32'h100, 0, 1,32'h080,1,16'd1}); // beq mispredict, lookup same idx
        tbl.push_back('{0,0,0,0,0,0, 32'h000,32'h000, 32'h100, 1, 0,32'h080,1,16'd1});
        tbl.push_back('{0,0,0,0,0,0, 32'h000,32'h000, 32'h204, 0, 0,32'h080,0,16'd1});
        tbl.push_back('{0,1,1,0,0,1, 32'h200,32'h300, 32'h200, 1, 1,32'h204,1,16'd2}); // bne not-taken, pred taken
        tbl.push_back('{0,0,0,0,0,0, 32'h000,32'h000, 32'h200, 0, 0,32'h204,1,16'd2});
        tbl.push_back('{0,0,0,0,0,0, 32'h000,32'h000, 32'h200, 0, 0,32'h204,0,16'd2});
        tbl.push_back('{0,1,1,0,0,0, 32'h200,32'h300, 32'h200, 0, 0,32'h204,0,16'd2}); // correct prediction
        tbl.push_back('{0,0,0,0,0,0, 32'h000,32'h000, 32'h200, 0, 0,32'h204,0,16'd2});
        tbl.push_back('{0,1,1,0,1,1, 32'h010,32'h040, 32'h010, 0, 0,32'h204,0,16'd2}); // train 01->10
        tbl.push_back('{0,1,1,0,1,1, 32'h010,32'h040, 32'h010, 1, 0,32'h204,0,16'd2}); // 10->11
        tbl.push_back('{0,1,1,0,1,1, 32'h010,32'h040, 32'h010, 1, 0,32'h204,0,16'd2}); // 11 stays
        tbl.push_back('{0,1,1,0,1,1, 32'h010,32'h040, 32'h010, 1, 0,32'h204,0,16'd2}); // 11 stays
        tbl.push_back('{0,1,1,0,0,1, 32'h010,32'h040, 32'h010, 1, 1,32'h014,1,16'd3}); // 11->10
        tbl.push_back('{0,0,0,0,0,0, 32'h000,32'h000, 32'h010, 1, 0,32'h014,1,16'd3});
        tbl.push_back('{0,0,0,0,0,0, 32'h000,32'h000, 32'h010, 1, 0,32'h014,0,16'd3});
        tbl.push_back('{0,1,0,1,0,0, 32'h020,32'h400, 32'h020, 0, 1,32'h400,1,16'd4}); // jal pred 0
        tbl.push_back('{0,0,0,0,0,0, 32'h000,32'h000, 32'h020, 0, 0,32'h400,1,16'd4});
        tbl.push_back('{0,0,0,0,0,0, 32'h000,32'h000, 32'h020, 0, 0,32'h400,0,16'd4});
        tbl.push_back('{0,1,1,1,0,1, 32'h020,32'h500, 32'h020, 0, 0,32'h400,0,16'd4}); // both flags: jal, no redirect
        tbl.push_back('{0,1,1,1,1,1, 32'h020,32'h500, 32'h020, 0, 0,32'h400,0,16'd4}); // both flags: no training
        tbl.push_back('{0,0,0,0,0,0, 32'h000,32'h000, 32'h020, 0, 0,32'h400,0,16'd4});
        tbl.push_back('{0,1,1,0,1,0, 32'h030,32'h500, 32'h030, 0, 1,32'h500,1,16'd5}); // mispredict then stall
        tbl.push_back('{1,0,0,0,0,0, 32'h000,32'h000, 32'h030, 1, 0,32'h500,1,16'd5});
        tbl.push_back('{1,0,0,0,0,0, 32'h000,32'h000, 32'h030, 1, 0,32'h500,1,16'd5});
        tbl.push_back('{1,0,0,0,0,0, 32'h000,32'h000, 32'h030, 1, 0,32'h500,1,16'd5});
        tbl.push_back('{0,1,1,0,0,1, 32'h030,32'h600, 32'h030, 1, 0,32'h500,1,16'd5}); // wrong path ignored
        tbl.push_back('{0,1,1,0,0,1, 32'h030,32'h600, 32'h030, 1, 0,32'h500,0,16'd5}); // wrong path ignored
        tbl.push_back('{0,0,0,0,0,0, 32'h000,32'h000, 32'h030, 1, 0,32'h500,0,16'd5});
        tbl.push_back('{1,1,1,0,0,1, 32'h030,32'h600, 32'h030, 1, 0,32'h500,0,16'd5}); // stall in idle
        tbl.push_back('{0,0,0,0,0,0, 32'h000,32'h000, 32'h030, 1, 0,32'h500,0,16'd5});

        foreach (tbl[i]) begin
            set_in(tbl[i].stall, tbl[i].valid, tbl[i].br, tbl[i].jal, tbl[i].taken,
                   tbl[i].pred, tbl[i].pc, tbl[i].tgt, tbl[i].ifpc);
            cycle_check($sformatf("vec%0d", i), tbl[i].e_pred, tbl[i].e_rv,
                        tbl[i].e_rpc, tbl[i].e_fl, tbl[i].e_cnt);
        end

        // Reset one cycle into a flush aborts it and restores the table
        set_in(0, 1, 1, 0, 1, 0, 32'h040, 32'h700, 32'h040);
        cycle_check("rflush enter", 1'b0, 1'b1, 32'h700, 1'b1, 16'd6);
        set_in(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'h040);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rflush redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rflush redirect_pc", redirect_pc, 32'd0);
        chk("rflush flush_ifid", {31'd0, flush_ifid}, 32'd0);
        chk("rflush flush_idex", {31'd0, flush_idex}, 32'd0);
        chk("rflush cnt", {16'd0, mispredict_cnt}, 32'd0);
        chk("rflush pred 0x40", {31'd0, if_pred_taken}, 32'd0);
        if_pc = 32'h030;
        #1;
        chk("rflush pred 0x30", {31'd0, if_pred_taken}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(0, 1, 1, 0, 1, 0, 32'h050, 32'h800, 32'h050);
        cycle_check("rflush idle", 1'b0, 1'b1, 32'h800, 1'b1, 16'd1);
        set_in(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'h050);
        cycle_check("rflush hold", 1'b1, 1'b0, 32'h800, 1'b1, 16'd1);
        cycle_check("rflush drop", 1'b1, 1'b0, 32'h800, 1'b0, 16'd1);

        // Randomized run against the reference model
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 800; n++) begin
            s   = ($urandom_range(0, 3) == 0);
            v   = ($urandom_range(0, 4) != 0);
            br  = $urandom_range(0, 1) == 1;
            jal = ($urandom_range(0, 5) == 0);
            tk  = $urandom_range(0, 1) == 1;
            pr  = $urandom_range(0, 1) == 1;
            pc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 95)) * 32'd4;
            tgt = $urandom;
            ipc = ($urandom_range(0, 1) == 1) ? pc : 32'($urandom_range(0, 95)) * 32'd4;
            set_in(s, v, br, jal, tk, pr, pc, tgt, ipc);

            e_pred = (m_bht[(ipc / 4) % BHT_ENTRIES] >= 2);
            m_rv = 1'b0;
            if (m_left == 0) begin
                if (v && !s && (br || jal)) begin
                    act = jal ? 1'b1 : tk;
                    if (br && !jal) begin
                        idx = (pc / 4) % BHT_ENTRIES;
                        if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
                        else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
                    end
                    if (act != pr) begin
                        m_left = FLUSH_CYCLES;
                        m_rv   = 1'b1;
                        m_rpc  = act ? tgt : pc + 32'd4;
                        m_fl   = 1'b1;
                        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                    end
                end
            end else if (!s) begin
                m_left--;
                if (m_left == 0) m_fl = 1'b0;
            end
            cycle_check($sformatf("rnd%0d", n), e_pred, m_rv, m_rpc, m_fl, 16'(m_cnt));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests=%0d failures=%0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
